// File: rtl/jts16_bank_sched.sv
// jts16_bank_sched: four-bank SDRAM request scheduler with auto-refresh insertion
// and in-order completion routing back to the issuing bank.
// Optional macro JTS16_BA0_PRIO_EN: bank 0 gets fixed priority, round-robin over banks 1-3.
module jts16_bank_sched #(
  parameter int OUTSTANDING = 2,
  parameter int REF_PERIOD  = 390
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [21:0] ba0_addr,
  input  logic        ba0_rd,
  input  logic        ba0_wr,
  input  logic [15:0] ba0_din,
  input  logic [1:0]  ba0_din_m,
  input  logic [21:0] ba1_addr,
  input  logic [21:0] ba2_addr,
  input  logic [21:0] ba3_addr,
  input  logic        ba1_rd,
  input  logic        ba2_rd,
  input  logic        ba3_rd,
  output logic        ba0_ack,
  output logic        ba1_ack,
  output logic        ba2_ack,
  output logic        ba3_ack,
  output logic        ba0_rdy,
  output logic        ba1_rdy,
  output logic        ba2_rdy,
  output logic        ba3_rdy,
  input  logic        refresh_en,
  output logic        cmd_req,
  output logic [1:0]  cmd_ba,
  output logic [21:0] cmd_addr,
  output logic        cmd_wr,
  output logic        cmd_ref,
  output logic [15:0] cmd_din,
  output logic [1:0]  cmd_mask,
  input  logic        cmd_gnt,
  input  logic        core_rdy,
  output logic        spurious
);

  localparam int REF_W = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REF_PERIOD - 1);
  localparam logic [2:0] OUT_MAX = 3'(OUTSTANDING);

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  state_t      state_q;
  logic        cmd_req_q;
  logic [1:0]  cmd_ba_q;
  logic [21:0] cmd_addr_q;
  logic        cmd_wr_q;
  logic        cmd_ref_q;
  logic [15:0] cmd_din_q;
  logic [1:0]  cmd_mask_q;
  logic [3:0]  ack_q;
  logic [1:0]  last_q;

  logic [3:0]  rdy_q;
  logic        spurious_q;
  logic [1:0]  tag_mem_q [4];
  logic [1:0]  wr_ptr_q;
  logic [1:0]  rd_ptr_q;
  logic [2:0]  cnt_q;
  logic [2:0]  cnt_d;

  logic [REF_W-1:0] ref_cnt_q;
  logic [REF_W-1:0] ref_cnt_d;
  logic [1:0]  ref_pend_q;
  logic [1:0]  ref_pend_d;

  logic [3:0]  req_vec;
  logic [3:0]  elig;
  logic        room;
  logic        pick_vld;
  logic [1:0]  pick_ba;
  logic [1:0]  cand;
  logic [21:0] pick_addr;
  logic        ref_tick;
  logic        ref_gnt;
  logic        ref_ok;
  logic        ref_urgent;
  logic        tag_push;
  logic        tag_pop;

  // A bank whose ack is pulsing this cycle is still holding its old request
  assign req_vec = {ba3_rd, ba2_rd, ba1_rd, ba0_rd | ba0_wr};
  assign room    = cnt_q < OUT_MAX;
  assign elig    = req_vec & ~ack_q & {4{room}};

  assign ref_tick   = (ref_cnt_q == REF_LAST);
  assign ref_gnt    = (state_q == S_ISSUE) && cmd_gnt && cmd_ref_q;
  assign tag_push   = (state_q == S_ISSUE) && cmd_gnt && !cmd_ref_q;
  assign tag_pop    = core_rdy && (cnt_q != 3'd0);
  // Refresh needs an idle core; urgency is only meaningful while refresh is allowed,
  // otherwise banks would starve for the whole active display period
  assign ref_ok     = refresh_en && (ref_pend_q != 2'd0) && (cnt_q == 3'd0);
  assign ref_urgent = refresh_en && (ref_pend_q == 2'd3);

  // Round-robin search starting just after the last granted bank
  always_comb begin
    pick_vld = 1'b0;
    pick_ba  = 2'd0;
    cand     = last_q;
`ifdef JTS16_BA0_PRIO_EN
    if (elig[0]) begin
      pick_vld = 1'b1;
      pick_ba  = 2'd0;
    end
    for (int i = 0; i < 3; i++) begin
      cand = (cand == 2'd3) ? 2'd1 : cand + 2'd1;
      if (!pick_vld && elig[cand]) begin
        pick_vld = 1'b1;
        pick_ba  = cand;
      end
    end
`else
    for (int i = 0; i < 4; i++) begin
      cand = cand + 2'd1;
      if (!pick_vld && elig[cand]) begin
        pick_vld = 1'b1;
        pick_ba  = cand;
      end
    end
`endif
  end

  // Address of the selected bank
  always_comb begin
    pick_addr = ba0_addr;
    case (pick_ba)
      2'd0: pick_addr = ba0_addr;
      2'd1: pick_addr = ba1_addr;
      2'd2: pick_addr = ba2_addr;
      2'd3: pick_addr = ba3_addr;
    endcase
  end

  // Command FSM: latch a source in IDLE, hold it stable in ISSUE until granted
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cmd_req_q  <= 1'b0;
      cmd_ba_q   <= 2'd0;
      cmd_addr_q <= 22'd0;
      cmd_wr_q   <= 1'b0;
      cmd_ref_q  <= 1'b0;
      cmd_din_q  <= 16'd0;
      cmd_mask_q <= 2'd0;
      ack_q      <= 4'd0;
      last_q     <= 2'd3;
    end else begin
      ack_q <= 4'd0;
      case (state_q)
        S_IDLE: begin
          if (ref_ok && (ref_urgent || !pick_vld)) begin
            state_q   <= S_ISSUE;
            cmd_req_q <= 1'b1;
            cmd_ref_q <= 1'b1;
            cmd_wr_q  <= 1'b0;
          end else if (pick_vld && !ref_urgent) begin
            state_q    <= S_ISSUE;
            cmd_req_q  <= 1'b1;
            cmd_ref_q  <= 1'b0;
            cmd_ba_q   <= pick_ba;
            cmd_addr_q <= pick_addr;
            cmd_wr_q   <= (pick_ba == 2'd0) && ba0_wr;
            cmd_din_q  <= ba0_din;
            cmd_mask_q <= ba0_din_m;
`ifdef JTS16_BA0_PRIO_EN
            if (pick_ba != 2'd0) last_q <= pick_ba;
`else
            last_q <= pick_ba;
`endif
          end
        end
        S_ISSUE: begin
          if (cmd_gnt) begin
            state_q   <= S_IDLE;
            cmd_req_q <= 1'b0;
            if (!cmd_ref_q) ack_q[cmd_ba_q] <= 1'b1;
          end
        end
      endcase
    end
  end

  // Refresh period counter and saturating credit count
  always_comb begin
    ref_cnt_d  = ref_tick ? '0 : ref_cnt_q + REF_W'(1);
    ref_pend_d = ref_pend_q;
    if (ref_tick && !ref_gnt && (ref_pend_q != 2'd3)) ref_pend_d = ref_pend_q + 2'd1;
    else if (!ref_tick && ref_gnt) ref_pend_d = ref_pend_q - 2'd1;
  end

  // Refresh state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_cnt_q  <= '0;
      ref_pend_q <= 2'd0;
    end else begin
      ref_cnt_q  <= ref_cnt_d;
      ref_pend_q <= ref_pend_d;
    end
  end

  // Occupancy of the in-order tag FIFO
  always_comb begin
    cnt_d = cnt_q;
    case ({tag_push, tag_pop})
      2'b10:   cnt_d = cnt_q + 3'd1;
      2'b01:   cnt_d = cnt_q - 3'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Tag FIFO: remember the bank of each granted access, route core_rdy back to it
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) tag_mem_q[i] <= 2'd0;
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      cnt_q      <= 3'd0;
      rdy_q      <= 4'd0;
      spurious_q <= 1'b0;
    end else begin
      rdy_q <= 4'd0;
      if (tag_push) begin
        tag_mem_q[wr_ptr_q] <= cmd_ba_q;
        wr_ptr_q            <= wr_ptr_q + 2'd1;
      end
      if (tag_pop) begin
        rdy_q[tag_mem_q[rd_ptr_q]] <= 1'b1;
        rd_ptr_q                   <= rd_ptr_q + 2'd1;
      end
      if (core_rdy && (cnt_q == 3'd0)) spurious_q <= 1'b1;
      cnt_q <= cnt_d;
    end
  end

  assign cmd_req  = cmd_req_q;
  assign cmd_ba   = cmd_ba_q;
  assign cmd_addr = cmd_addr_q;
  assign cmd_wr   = cmd_wr_q;
  assign cmd_ref  = cmd_ref_q;
  assign cmd_din  = cmd_din_q;
  assign cmd_mask = cmd_mask_q;
  assign ba0_ack  = ack_q[0];
  assign ba1_ack  = ack_q[1];
  assign ba2_ack  = ack_q[2];
  assign ba3_ack  = ack_q[3];
  assign ba0_rdy  = rdy_q[0];
  assign ba1_rdy  = rdy_q[1];
  assign ba2_rdy  = rdy_q[2];
  assign ba3_rdy  = rdy_q[3];
  assign spurious = spurious_q;

endmodule

// File: tb/tb_jts16_bank_sched.sv
// Bench for jts16_bank_sched: directed scenarios plus a randomized run against a
// transaction-level model of arbitration, grant timing and in-order completion.
module tb_jts16_bank_sched;
  localparam int OUTS = 2;
  localparam int RP   = 8;

  logic        clk, rst;
  logic [21:0] ba0_addr, ba1_addr, ba2_addr, ba3_addr;
  logic        ba0_rd, ba0_wr, ba1_rd, ba2_rd, ba3_rd;
  logic [15:0] ba0_din;
  logic [1:0]  ba0_din_m;
  logic        ba0_ack, ba1_ack, ba2_ack, ba3_ack;
  logic        ba0_rdy, ba1_rdy, ba2_rdy, ba3_rdy;
  logic        refresh_en, cmd_req, cmd_wr, cmd_ref, cmd_gnt, core_rdy, spurious;
  logic [1:0]  cmd_ba, cmd_mask;
  logic [21:0] cmd_addr;
  logic [15:0] cmd_din;

  int total, bad;

  // model state
  logic        e_req, e_wr, e_spur;
  logic [1:0]  e_ba, e_mask;
  logic [21:0] e_addr;
  logic [15:0] e_din;
  logic [3:0]  e_ack, e_rdy;
  int          m_last;
  int          m_q[$];

  wire [3:0] acks = {ba3_ack, ba2_ack, ba1_ack, ba0_ack};
  wire [3:0] rdys = {ba3_rdy, ba2_rdy, ba1_rdy, ba0_rdy};

  jts16_bank_sched #(.OUTSTANDING(OUTS), .REF_PERIOD(RP)) dut (
    .clk(clk), .rst(rst),
    .ba0_addr(ba0_addr), .ba0_rd(ba0_rd), .ba0_wr(ba0_wr), .ba0_din(ba0_din), .ba0_din_m(ba0_din_m),
    .ba1_addr(ba1_addr), .ba2_addr(ba2_addr), .ba3_addr(ba3_addr),
    .ba1_rd(ba1_rd), .ba2_rd(ba2_rd), .ba3_rd(ba3_rd),
    .ba0_ack(ba0_ack), .ba1_ack(ba1_ack), .ba2_ack(ba2_ack), .ba3_ack(ba3_ack),
    .ba0_rdy(ba0_rdy), .ba1_rdy(ba1_rdy), .ba2_rdy(ba2_rdy), .ba3_rdy(ba3_rdy),
    .refresh_en(refresh_en), .cmd_req(cmd_req), .cmd_ba(cmd_ba), .cmd_addr(cmd_addr),
    .cmd_wr(cmd_wr), .cmd_ref(cmd_ref), .cmd_din(cmd_din), .cmd_mask(cmd_mask),
    .cmd_gnt(cmd_gnt), .core_rdy(core_rdy), .spurious(spurious)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required run to complete");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ba0_addr = '0; ba1_addr = '0; ba2_addr = '0; ba3_addr = '0;
    ba0_rd = 0; ba0_wr = 0; ba1_rd = 0; ba2_rd = 0; ba3_rd = 0;
    ba0_din = '0; ba0_din_m = '0; refresh_en = 0; cmd_gnt = 0; core_rdy = 0;
  endtask

  // leaves the bench in cycle 0: DUT just reset, inputs may be set for this cycle
  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if ({cmd_req, cmd_wr, cmd_ref, cmd_ba, cmd_mask} !== 7'd0) begin bad++;
      $display("FAIL reset_ctl: got %b required 0", {cmd_req, cmd_wr, cmd_ref, cmd_ba, cmd_mask}); end
    total++; if ({cmd_addr, cmd_din} !== 38'd0) begin bad++;
      $display("FAIL reset_data: got %h required 0", {cmd_addr, cmd_din}); end
    total++; if ({acks, rdys, spurious} !== 9'd0) begin bad++;
      $display("FAIL reset_pulses: got %b required 0", {acks, rdys, spurious}); end
    // reset while a command is waiting for grant
    ba2_rd = 1;
    tick();
    total++; if (cmd_req !== 1'b1) begin bad++; $display("FAIL rst_issue_req: got %b required 1", cmd_req); end
    rst = 1; cmd_gnt = 1;
    tick();
    total++; if ({cmd_req, acks} !== 5'd0) begin bad++;
      $display("FAIL rst_in_issue: got %b required 0", {cmd_req, acks}); end
    rst = 0; ba2_rd = 0; cmd_gnt = 0;
    tick();
    total++; if (acks !== 4'd0) begin bad++; $display("FAIL rst_no_ack: got %b required 0", acks); end
  endtask

  task automatic test_single_read();
    do_reset();
    ba1_addr = 22'h2A5F3C; ba1_rd = 1; cmd_gnt = 1;
    tick(); // cycle 1
    total++; if ({cmd_req, cmd_ba, cmd_wr, cmd_ref} !== 5'b1_01_0_0) begin bad++;
      $display("FAIL single_cmd: got %b required 10100", {cmd_req, cmd_ba, cmd_wr, cmd_ref}); end
    total++; if (cmd_addr !== 22'h2A5F3C) begin bad++;
      $display("FAIL single_addr: got %h required 2a5f3c", cmd_addr); end
    total++; if (acks !== 4'd0) begin bad++; $display("FAIL single_early_ack: got %b required 0", acks); end
    tick(); // cycle 2
    total++; if ({acks, cmd_req} !== 5'b0010_0) begin bad++;
      $display("FAIL single_ack: got %b required 00100", {acks, cmd_req}); end
    ba1_rd = 0;
    tick(); // cycle 3
    total++; if (cmd_req !== 1'b0) begin bad++; $display("FAIL single_no_rereq: got %b required 0", cmd_req); end
    tick(); tick(); // cycle 5
    core_rdy = 1;
    tick(); // cycle 6
    total++; if (rdys !== 4'b0010) begin bad++; $display("FAIL single_rdy: got %b required 0010", rdys); end
    core_rdy = 0;
    tick(); // cycle 7
    total++; if ({rdys, spurious} !== 5'd0) begin bad++;
      $display("FAIL single_rdy_once: got %b required 0", {rdys, spurious}); end
    cmd_gnt = 0;
  endtask

  task automatic test_write_stall();
    do_reset();
    ba0_wr = 1; ba0_din = 16'hA55A; ba0_din_m = 2'b01; ba0_addr = 22'h00F0F0;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if ({cmd_req, cmd_wr, cmd_ba, cmd_din, cmd_mask, cmd_addr} !== {1'b1, 1'b1, 2'd0, 16'hA55A, 2'b01, 22'h00F0F0}) begin bad++;
        $display("FAIL wr_hold%0d: got %h/%h/%b req=%b wr=%b required 00f0f0/a55a/01 req=1 wr=1", i, cmd_addr, cmd_din, cmd_mask, cmd_req, cmd_wr); end
      ba0_din = 16'($urandom); ba0_addr = 22'($urandom); ba0_din_m = 2'($urandom);
    end
    cmd_gnt = 1;
    tick();
    total++; if ({acks, cmd_req} !== 5'b0001_0) begin bad++;
      $display("FAIL wr_ack: got %b required 00010", {acks, cmd_req}); end
    ba0_wr = 0; cmd_gnt = 0; core_rdy = 1;
    tick();
    total++; if ({rdys, cmd_req} !== 5'b0001_0) begin bad++;
      $display("FAIL wr_rdy: got %b required 00010", {rdys, cmd_req}); end
    core_rdy = 0;
  endtask

  task automatic test_outstanding();
    do_reset();
    ba1_addr = 22'h111; ba2_addr = 22'h222; ba3_addr = 22'h333;
    ba1_rd = 1; ba2_rd = 1; ba3_rd = 1; cmd_gnt = 1;
    tick(); // 1
    total++; if ({cmd_req, cmd_ba} !== 3'b1_01) begin bad++; $display("FAIL os_first: got %b required 101", {cmd_req, cmd_ba}); end
    tick(); // 2
    total++; if (acks !== 4'b0010) begin bad++; $display("FAIL os_ack1: got %b required 0010", acks); end
    ba1_rd = 0;
    tick(); // 3
    total++; if ({cmd_req, cmd_ba, cmd_addr} !== {1'b1, 2'd2, 22'h222}) begin bad++;
      $display("FAIL os_second: got %b/%h required 1/2/222", {cmd_req, cmd_ba}, cmd_addr); end
    tick(); // 4
    total++; if (acks !== 4'b0100) begin bad++; $display("FAIL os_ack2: got %b required 0100", acks); end
    ba2_rd = 0;
    for (int i = 0; i < 4; i++) begin
      tick(); // 5..8
      total++; if ({cmd_req, acks} !== 5'd0) begin bad++;
        $display("FAIL os_blocked%0d: got %b required 0", i, {cmd_req, acks}); end
    end
    core_rdy = 1;
    tick(); // 9
    total++; if (rdys !== 4'b0010) begin bad++; $display("FAIL os_rdy1: got %b required 0010", rdys); end
    core_rdy = 0;
    tick(); // 10
    total++; if ({cmd_req, cmd_ba} !== 3'b1_11) begin bad++; $display("FAIL os_third: got %b required 111", {cmd_req, cmd_ba}); end
    tick(); // 11
    total++; if (acks !== 4'b1000) begin bad++; $display("FAIL os_ack3: got %b required 1000", acks); end
    ba3_rd = 0; core_rdy = 1; cmd_gnt = 0;
    tick(); // 12
    total++; if (rdys !== 4'b0100) begin bad++; $display("FAIL os_rdy2: got %b required 0100", rdys); end
    tick(); // 13
    total++; if (rdys !== 4'b1000) begin bad++; $display("FAIL os_rdy3: got %b required 1000", rdys); end
    core_rdy = 0;
    tick(); // 14
    total++; if ({rdys, spurious} !== 5'd0) begin bad++; $display("FAIL os_drained: got %b required 0", {rdys, spurious}); end
  endtask

  task automatic test_round_robin();
    int got[6];
    int exp_ord[6];
    int n;
`ifdef JTS16_BA0_PRIO_EN
    exp_ord = '{0, 1, 0, 2, 0, 3};
`else
    exp_ord = '{0, 1, 2, 3, 0, 1};
`endif
    n = 0;
    do_reset();
    ba0_rd = 1; ba1_rd = 1; ba2_rd = 1; ba3_rd = 1; cmd_gnt = 1;
    for (int c = 0; c < 30; c++) begin
      tick();
      for (int b = 0; b < 4; b++) if (acks[b]) begin
        if (n < 6) got[n] = b;
        n++;
      end
      core_rdy = |acks;
      ba0_rd = !acks[0]; ba1_rd = !acks[1]; ba2_rd = !acks[2]; ba3_rd = !acks[3];
    end
    total++; if (n < 6) begin bad++; $display("FAIL rr_count: got %0d grants required at least 6", n); end
    else for (int i = 0; i < 6; i++) begin
      total++; if (got[i] !== exp_ord[i]) begin bad++;
        $display("FAIL rr_order%0d: got bank %0d required bank %0d", i, got[i], exp_ord[i]); end
    end
    idle_inputs();
    tick();
    total++; if (spurious !== 1'b0) begin bad++; $display("FAIL rr_spurious: got %b required 0", spurious); end
  endtask

  task automatic test_refresh();
    logic seen;
    do_reset();
    cmd_gnt = 1;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      seen |= cmd_req;
    end
    // cycle 40: three credits accrued while refresh was disabled
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL ref_disabled: got req=%b required 0", seen); end
    refresh_en = 1; ba2_rd = 1; ba2_addr = 22'h3ABCD;
    tick(); // 41
    total++; if ({cmd_req, cmd_ref} !== 2'b11) begin bad++; $display("FAIL ref_urgent_first: got %b required 11", {cmd_req, cmd_ref}); end
    tick(); // 42
    total++; if ({acks, cmd_req} !== 5'd0) begin bad++; $display("FAIL ref_no_ack: got %b required 0", {acks, cmd_req}); end
    tick(); // 43
    total++; if ({cmd_req, cmd_ref, cmd_ba, cmd_addr} !== {2'b10, 2'd2, 22'h3ABCD}) begin bad++;
      $display("FAIL ref_then_bank: got %b/%h required 1010/3abcd", {cmd_req, cmd_ref, cmd_ba}, cmd_addr); end
    tick(); // 44
    total++; if (acks !== 4'b0100) begin bad++; $display("FAIL ref_bank_ack: got %b required 0100", acks); end
    ba2_rd = 0; core_rdy = 1;
    tick(); // 45
    total++; if ({rdys, cmd_req} !== 5'b0100_0) begin bad++;
      $display("FAIL ref_wait_empty: got %b required 01000", {rdys, cmd_req}); end
    core_rdy = 0;
    tick(); // 46
    total++; if ({cmd_req, cmd_ref} !== 2'b11) begin bad++; $display("FAIL ref_idle_issue: got %b required 11", {cmd_req, cmd_ref}); end
    tick(); // 47
    total++; if ({cmd_req, acks} !== 5'd0) begin bad++; $display("FAIL ref_done: got %b required 0", {cmd_req, acks}); end
    idle_inputs();
  endtask

  task automatic test_spurious();
    do_reset();
    core_rdy = 1;
    tick();
    total++; if ({spurious, rdys} !== 5'b1_0000) begin bad++;
      $display("FAIL spur_set: got %b required 10000", {spurious, rdys}); end
    core_rdy = 0;
    tick(); tick();
    total++; if ({spurious, rdys} !== 5'b1_0000) begin bad++;
      $display("FAIL spur_sticky: got %b required 10000", {spurious, rdys}); end
    rst = 1;
    tick();
    total++; if (spurious !== 1'b0) begin bad++; $display("FAIL spur_clear: got %b required 0", spurious); end
    rst = 0;
  endtask

  // advances the model across one clock edge using the inputs currently driven
  task automatic model_edge();
    logic [3:0] req, elig, nack, nrdy;
    int pre, b, pushb, t;
    bit found;
    req = {ba3_rd, ba2_rd, ba1_rd, ba0_rd | ba0_wr};
    pre = m_q.size();
    nack = '0; nrdy = '0; pushb = -1; found = 0; b = 0;
    for (int n = 0; n < 4; n++) elig[n] = req[n] && !e_ack[n] && (pre < OUTS);
    if (!e_req) begin
`ifdef JTS16_BA0_PRIO_EN
      if (elig[0]) begin found = 1; b = 0; end
      for (int k = 1; k <= 3; k++)
        if (!found && elig[((m_last - 1 + k) % 3) + 1]) begin found = 1; b = ((m_last - 1 + k) % 3) + 1; end
      if (found && b != 0) m_last = b;
`else
      for (int k = 1; k <= 4; k++)
        if (!found && elig[(m_last + k) % 4]) begin found = 1; b = (m_last + k) % 4; end
      if (found) m_last = b;
`endif
      if (found) begin
        e_req = 1;
        e_ba = b[1:0];
        e_wr = (b == 0) && ba0_wr;
        e_addr = (b == 0) ? ba0_addr : (b == 1) ? ba1_addr : (b == 2) ? ba2_addr : ba3_addr;
        if (b == 0) begin e_din = ba0_din; e_mask = ba0_din_m; end
      end
    end else if (cmd_gnt) begin
      e_req = 0;
      nack[e_ba] = 1'b1;
      pushb = int'(e_ba);
    end
    if (core_rdy) begin
      if (pre == 0) e_spur = 1;
      else begin t = m_q.pop_front(); nrdy[t] = 1'b1; end
    end
    if (pushb >= 0) m_q.push_back(pushb);
    e_ack = nack;
    e_rdy = nrdy;
  endtask

  task automatic test_random();
    logic [3:0] rq;
    int r;
    do_reset();
    e_req = 0; e_wr = 0; e_spur = 0; e_ba = 0; e_mask = 0; e_addr = 0; e_din = 0;
    e_ack = 0; e_rdy = 0; m_last = 3; m_q.delete();
    rq = 0;
    for (int c = 0; c < 600; c++) begin
      for (int n = 0; n < 4; n++) begin
        if (rq[n]) begin
          if (e_ack[n] && $urandom_range(0, 1) == 1) rq[n] = 0;
        end else if ($urandom_range(0, 9) < 4) begin
          rq[n] = 1;
          case (n)
            0: begin r = $urandom_range(1, 3); ba0_rd = r[0]; ba0_wr = r[1]; ba0_addr = 22'($urandom); end
            1: ba1_addr = 22'($urandom);
            2: ba2_addr = 22'($urandom);
            default: ba3_addr = 22'($urandom);
          endcase
        end
      end
      if (!rq[0]) begin ba0_rd = 0; ba0_wr = 0; end
      ba1_rd = rq[1]; ba2_rd = rq[2]; ba3_rd = rq[3];
      ba0_din = 16'($urandom); ba0_din_m = 2'($urandom);
      cmd_gnt = ($urandom_range(0, 1) == 1);
      core_rdy = (m_q.size() > 0) && ($urandom_range(0, 2) == 0);
      model_edge();
      tick();
      total++; if (cmd_req !== e_req) begin bad++; $display("FAIL rnd_req c%0d: got %b required %b", c, cmd_req, e_req); end
      if (e_req) begin
        total++; if ({cmd_ba, cmd_wr, cmd_ref, cmd_addr} !== {e_ba, e_wr, 1'b0, e_addr}) begin bad++;
          $display("FAIL rnd_cmd c%0d: got ba=%0d wr=%b ref=%b addr=%h required ba=%0d wr=%b ref=0 addr=%h",
                   c, cmd_ba, cmd_wr, cmd_ref, cmd_addr, e_ba, e_wr, e_addr); end
        if (e_wr) begin
          total++; if ({cmd_din, cmd_mask} !== {e_din, e_mask}) begin bad++;
            $display("FAIL rnd_wdata c%0d: got %h/%b required %h/%b", c, cmd_din, cmd_mask, e_din, e_mask); end
        end
      end
      total++; if (acks !== e_ack) begin bad++; $display("FAIL rnd_ack c%0d: got %b required %b", c, acks, e_ack); end
      total++; if (rdys !== e_rdy) begin bad++; $display("FAIL rnd_rdy c%0d: got %b required %b", c, rdys, e_rdy); end
      total++; if (spurious !== e_spur) begin bad++; $display("FAIL rnd_spur c%0d: got %b required %b", c, spurious, e_spur); end
    end
    idle_inputs();
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1;
    idle_inputs();
    test_reset();
    test_single_read();
    test_write_stall();
    test_outstanding();
    test_round_robin();
    test_refresh();
    test_spurious();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
